// File: rtl/nes_input_pkg.sv
// Shared constants for the NES controller-port read stage.
// Holds button bit positions, report lengths, the Four Score signature
// bytes (LSB is shifted out first) and the CPU data-bus bit positions
// used when merging pad and zapper lines.
package nes_input_pkg;

    // Button bit positions within a standard pad report.
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // Serial report lengths.
    localparam int unsigned STD_REPORT_LEN = 8;
    localparam int unsigned FS_REPORT_LEN  = 24;

    // Four Score signature bytes sent after the second pad of each port.
    localparam logic [7:0] FS_SIG_P1 = 8'b0000_1000;
    localparam logic [7:0] FS_SIG_P2 = 8'b0000_0100;

    // Port data bit positions (D4..D0 bus slice).
    localparam int unsigned PORT_D0 = 0;
    localparam int unsigned PORT_D3 = 3;
    localparam int unsigned PORT_D4 = 4;

endpackage

// File: rtl/nes_pad_shifter.sv
// Serial report shifter for one controller port.
// While strobe_i is high the register reloads from reload_i every cycle and
// the read counter clears. With strobe_i low, each read_i pulse shifts right
// by one (filling with 1) and advances a counter that saturates at ReportLen.
// Ports:
//   clk_i, reset_ni   clock, synchronous active-low reset
//   reload_i          parallel report, bit 0 shifted out first
//   strobe_i          reload enable (level)
//   read_i            one-cycle read pulse
//   serial_o          current LSB of the shift register
//   exhausted_o       all ReportLen bits have been read
module nes_pad_shifter #(
    parameter int unsigned ReportLen = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [ReportLen-1:0] reload_i,
    input  logic                 strobe_i,
    input  logic                 read_i,
    output logic                 serial_o,
    output logic                 exhausted_o
);

    localparam int unsigned    CntW   = $clog2(ReportLen + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(ReportLen);

    logic [ReportLen-1:0] shift_q, shift_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (strobe_i) begin
            // Reload wins over any read pulse in the same cycle.
            shift_d = reload_i;
            cnt_d   = '0;
        end else if (read_i) begin
            shift_d = {1'b1, shift_q[ReportLen-1:1]};
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign serial_o    = shift_q[0];
    assign exhausted_o = (cnt_q == CntMax);

endmodule

// File: rtl/nes_input_port.sv
// Controller-port read stage: latches pad reports on the CPU strobe and
// serialises them one bit per $4016/$4017 read. Port 2 optionally carries
// the zapper, whose light/trigger lines appear on D3/D4 and which forces D0
// low.
// Build option: define NES_FOURSCORE_EN for 24-bit Four Score reports
// (adds joy3_buttons/joy4_buttons).
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   joypad_strobe                   $4016 bit 0 latch level
//   port1_read, port2_read          one-cycle read pulses
//   joy1_buttons, joy2_buttons      live pad buttons (bit 0 = A)
//   joy3_buttons, joy4_buttons      Four Score pads (option only)
//   zapper_enabled/light/trigger    zapper presence and lines on port 2
//   port1_data, port2_data          D4..D0 for the CPU read mux
module nes_input_port
    import nes_input_pkg::*;
#(
    parameter int unsigned PAD_BITS = STD_REPORT_LEN
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                joypad_strobe,
    input  logic                port1_read,
    input  logic                port2_read,
    input  logic [PAD_BITS-1:0] joy1_buttons,
    input  logic [PAD_BITS-1:0] joy2_buttons,
`ifdef NES_FOURSCORE_EN
    input  logic [PAD_BITS-1:0] joy3_buttons,
    input  logic [PAD_BITS-1:0] joy4_buttons,
`endif
    input  logic                zapper_enabled,
    input  logic                zapper_light,
    input  logic                zapper_trigger,
    output logic [4:0]          port1_data,
    output logic [4:0]          port2_data
);

`ifdef NES_FOURSCORE_EN
    localparam int unsigned ReportLen = 2 * PAD_BITS + 8;
`else
    localparam int unsigned ReportLen = PAD_BITS;
`endif

    logic [ReportLen-1:0] reload1, reload2;

`ifdef NES_FOURSCORE_EN
    assign reload1 = {FS_SIG_P1, joy3_buttons, joy1_buttons};
    assign reload2 = {FS_SIG_P2, joy4_buttons, joy2_buttons};
`else
    assign reload1 = joy1_buttons;
    assign reload2 = joy2_buttons;
`endif

    logic p1_serial, p1_exhausted;
    logic p2_serial, p2_exhausted;

    nes_pad_shifter #(
        .ReportLen (ReportLen)
    ) u_shift_p1 (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .reload_i    (reload1),
        .strobe_i    (joypad_strobe),
        .read_i      (port1_read),
        .serial_o    (p1_serial),
        .exhausted_o (p1_exhausted)
    );

    nes_pad_shifter #(
        .ReportLen (ReportLen)
    ) u_shift_p2 (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .reload_i    (reload2),
        .strobe_i    (joypad_strobe),
        .read_i      (port2_read),
        .serial_o    (p2_serial),
        .exhausted_o (p2_exhausted)
    );

    // Zapper lines and presence are registered so a mid-report toggle
    // switches the port 2 view cleanly on the next cycle.
    logic zap_en_q, zap_light_q, zap_trig_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zap_en_q    <= 1'b0;
            zap_light_q <= 1'b0;
            zap_trig_q  <= 1'b0;
        end else begin
            zap_en_q    <= zapper_enabled;
            zap_light_q <= zapper_light;
            zap_trig_q  <= zapper_trigger;
        end
    end

    always_comb begin
        port1_data          = '0;
        port1_data[PORT_D0] = p1_exhausted | p1_serial;

        port2_data = '0;
        if (zap_en_q) begin
            port2_data[PORT_D3] = zap_light_q;
            port2_data[PORT_D4] = zap_trig_q;
        end else begin
            port2_data[PORT_D0] = p2_exhausted | p2_serial;
        end
    end

endmodule
